// File: rtl/enytank_spawn_sched_if.sv
// Tank-side handshake of the enemy spawn scheduler: the alive flags coming back from the
// four enemy tanks and the one-hot resurrection enable going out to them.
interface enytank_spawn_sched_if;
  logic [3:0] tank_state;
  logic [3:0] tank_en;

  // Scheduler side: watches alive flags, drives resurrection enables.
  modport master (
    input  tank_state,
    output tank_en
  );

  // Tank side: reports alive flags, receives resurrection enables.
  modport slave (
    output tank_state,
    input  tank_en
  );
endinterface

// File: rtl/enytank_spawn_sched.sv
// Enemy tank respawn scheduler. Waits respawn_delay game ticks (paused while the reward
// freeze is active), picks the next dead tank round-robin and holds its resurrection
// enable until the tank reports alive or ACK_TIMEOUT ticks pass.
// ACK_TIMEOUT must be at least 1.
module enytank_spawn_sched #(
  parameter int unsigned ACK_TIMEOUT = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  tick,
  input  logic                  reward_frozen,
  input  logic [2:0]            max_alive,
  input  logic [3:0]            respawn_delay,
  enytank_spawn_sched_if.master tank_io,
  output logic                  busy,
  output logic [2:0]            alive_cnt,
  output logic [7:0]            spawn_total,
  output logic                  timeout_err
);

  localparam int unsigned TmoW = ($clog2(ACK_TIMEOUT + 1) < 1) ? 1 : $clog2(ACK_TIMEOUT + 1);
  localparam logic [TmoW-1:0] TmoLimit = TmoW'(ACK_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StDelay, StSelect, StGrant} state_e;

  state_e          state_q, state_d;
  logic [3:0]      dly_q, dly_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      idx_q, idx_d;
  logic [2:0]      alive_cnt_q, alive_cnt_d;
  logic [7:0]      spawn_total_q, spawn_total_d;
  logic            timeout_err_q, timeout_err_d;

  logic [2:0]      limit;
  logic            spawn_ok;
  logic            sel_found;
  logic [1:0]      sel_idx;
  logic [1:0]      cand;

  // Alive popcount, clamped limit and round-robin search for the next dead tank.
  always_comb begin
    alive_cnt_d = '0;
    for (int i = 0; i < 4; i++) begin
      alive_cnt_d = alive_cnt_d + 3'(tank_io.tank_state[i]);
    end

    limit    = (max_alive > 3'd4) ? 3'd4 : max_alive;
    spawn_ok = enable && (alive_cnt_q < limit) && (tank_io.tank_state != 4'hF);

    // Search order ptr+1, ptr+2, ptr+3, ptr; k=4 truncates back to ptr itself.
    sel_found = 1'b0;
    sel_idx   = ptr_q;
    cand      = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = ptr_q + 2'(k);
      if (!sel_found && !tank_io.tank_state[cand]) begin
        sel_found = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Next-state logic for the spawn FSM and its counters.
  always_comb begin
    state_d       = state_q;
    dly_d         = dly_q;
    tmo_d         = tmo_q;
    ptr_d         = ptr_q;
    idx_d         = idx_q;
    spawn_total_d = spawn_total_q;
    timeout_err_d = timeout_err_q;

    if (!enable) begin
      // Leaving game mode wipes the round but keeps the sticky error visible.
      state_d       = StIdle;
      dly_d         = '0;
      tmo_d         = '0;
      ptr_d         = 2'd3;
      spawn_total_d = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (spawn_ok) begin
            if (respawn_delay == 4'd0) begin
              state_d = StSelect;
            end else begin
              state_d = StDelay;
              dly_d   = respawn_delay;
            end
          end
        end
        StDelay: begin
          if (dly_q == 4'd0) begin
            state_d = StSelect;
          end else if (tick && !reward_frozen) begin
            dly_d = dly_q - 4'd1;
          end
        end
        StSelect: begin
          // alive_cnt may have moved since IDLE, so the limit is checked again.
          if (sel_found && (alive_cnt_q < limit)) begin
            state_d = StGrant;
            idx_d   = sel_idx;
            tmo_d   = '0;
          end else begin
            state_d = StIdle;
          end
        end
        StGrant: begin
          // Ack is tested first so it wins over a coincident final timeout tick.
          if (tank_io.tank_state[idx_q]) begin
            state_d = StIdle;
            ptr_d   = idx_q;
            if (spawn_total_q != 8'hFF) begin
              spawn_total_d = spawn_total_q + 8'd1;
            end
          end else if (tick) begin
            if (tmo_q >= TmoLimit - TmoW'(1)) begin
              state_d       = StIdle;
              tmo_d         = TmoLimit;
              timeout_err_d = 1'b1;
              ptr_d         = idx_q;
            end else begin
              tmo_d = tmo_q + TmoW'(1);
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      dly_q         <= '0;
      tmo_q         <= '0;
      ptr_q         <= 2'd3;
      idx_q         <= '0;
      alive_cnt_q   <= '0;
      spawn_total_q <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      dly_q         <= dly_d;
      tmo_q         <= tmo_d;
      ptr_q         <= ptr_d;
      idx_q         <= idx_d;
      alive_cnt_q   <= alive_cnt_d;
      spawn_total_q <= spawn_total_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  // Enable decoded from the registered state so reset drops it on the same edge.
  assign tank_io.tank_en = (state_q == StGrant) ? (4'b0001 << idx_q) : 4'b0000;
  assign busy            = (state_q != StIdle);
  assign alive_cnt       = alive_cnt_q;
  assign spawn_total     = spawn_total_q;
  assign timeout_err     = timeout_err_q;

endmodule
